// File: rtl/btn_cond_if.sv
// Push-button conditioner signal bundle: raw button levels in, press pulses and debounced levels out.
interface btn_cond_if;
  logic raw_a;
  logic raw_b;
  logic a;
  logic b;
  logic a_lvl;
  logic b_lvl;

  modport master (output raw_a, raw_b, input a, b, a_lvl, b_lvl);
  modport slave  (input raw_a, raw_b, output a, b, a_lvl, b_lvl);
endinterface

// File: rtl/btn_cond.sv
// Two-channel push-button conditioner: 2-flop sync, optional debounce, arbitrated press pulses.
// Define BTN_COND_DEBOUNCE_EN to build in the per-channel debounce FSMs and counters.
module btn_cond #(
  parameter int DB_CYCLES = 4
) (
  input  logic      En,
  input  logic      rst,
  btn_cond_if.slave bus
);

  if (DB_CYCLES < 1 || DB_CYCLES > 255) begin : g_db_range
    $error("btn_cond: DB_CYCLES must be within 1..255");
  end

  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] lvl;
  logic [1:0] rise;
  logic       a_q;
  logic       b_q;
  logic       pend_b;

  assign raw = {bus.raw_b, bus.raw_a};

  always_ff @(posedge En or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef BTN_COND_DEBOUNCE_EN
  // state       | meaning
  // ST_LOW      | released, waiting for a synchronized press
  // ST_RISE_CHK | press seen, counting stable-high samples
  // ST_HIGH     | pressed, waiting for a synchronized release
  // ST_FALL_CHK | release seen, counting stable-low samples
  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {ST_LOW, ST_RISE_CHK, ST_HIGH, ST_FALL_CHK} state_t;

  state_t        state   [2];
  logic [CW-1:0] cnt     [2];
  logic [CW-1:0] cnt_inc [2];

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      cnt_inc[i] = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CW'(1);
      rise[i]    = (state[i] == ST_RISE_CHK) && sync2[i] && (cnt_inc[i] == CNT_DONE);
    end
  end

  always_ff @(posedge En or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= ST_LOW;
        cnt[i]   <= '0;
      end
      lvl <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        case (state[i])
          ST_LOW: begin
            if (sync2[i]) begin
              state[i] <= ST_RISE_CHK;
              cnt[i]   <= '0;
            end
          end
          ST_RISE_CHK: begin
            if (!sync2[i]) begin
              state[i] <= ST_LOW;
              cnt[i]   <= '0;
            end else if (cnt_inc[i] == CNT_DONE) begin
              state[i] <= ST_HIGH;
              cnt[i]   <= '0;
              lvl[i]   <= 1'b1;
            end else begin
              cnt[i] <= cnt_inc[i];
            end
          end
          ST_HIGH: begin
            if (!sync2[i]) begin
              state[i] <= ST_FALL_CHK;
              cnt[i]   <= '0;
            end
          end
          ST_FALL_CHK: begin
            if (sync2[i]) begin
              state[i] <= ST_HIGH;
              cnt[i]   <= '0;
            end else if (cnt_inc[i] == CNT_DONE) begin
              state[i] <= ST_LOW;
              cnt[i]   <= '0;
              lvl[i]   <= 1'b0;
            end else begin
              cnt[i] <= cnt_inc[i];
            end
          end
          default: begin
            state[i] <= ST_LOW;
            cnt[i]   <= '0;
            lvl[i]   <= 1'b0;
          end
        endcase
      end
    end
  end
`else
  // Extra delay stage keeps the pulse one edge behind the level, matching the debounced timing shape.
  logic [1:0] lvl_d;

  always_ff @(posedge En or negedge rst) begin
    if (!rst) begin
      lvl   <= '0;
      lvl_d <= '0;
    end else begin
      lvl   <= sync2;
      lvl_d <= lvl;
    end
  end

  assign rise = lvl & ~lvl_d;
`endif

  // Channel a wins a same-edge tie; b is deferred so the two pulses never overlap.
  always_ff @(posedge En or negedge rst) begin
    if (!rst) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      pend_b <= 1'b0;
    end else begin
      a_q    <= rise[0];
      b_q    <= (rise[1] | pend_b) & ~rise[0];
      pend_b <= (rise[1] | pend_b) & rise[0];
    end
  end

  assign bus.a     = a_q;
  assign bus.b     = b_q;
  assign bus.a_lvl = lvl[0];
  assign bus.b_lvl = lvl[1];

endmodule

// File: tb/tb_btn_cond.sv
// Bench for btn_cond: directed scenarios plus random button activity against a run-length reference model.
module tb_btn_cond;

  localparam int DB = 4;
`ifdef BTN_COND_DEBOUNCE_EN
  localparam bit DEB = 1'b1;
`else
  localparam bit DEB = 1'b0;
`endif
  localparam int LAT = DEB ? DB + 2 : 3;

  logic En;
  logic rst;
  btn_cond_if bus ();

  btn_cond #(.DB_CYCLES(DB)) dut (
    .En  (En),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    En = 1'b0;
    forever #10 En = ~En;
  end

  int total = 0;
  int bad   = 0;

  // Reference model: h[i][k] is the raw level sampled k edges ago
  logic [4:0] h [2];
  int         run [2];
  logic       m_lvl [2];
  logic       m_pend;
  logic       exp_a;
  logic       exp_b;

  int   edge_no;
  int   a_cnt, b_cnt, a_at, b_at;
  logic a_lvl_at, b_lvl_at, a_drop;

  task automatic chk(input string tag, input logic obs, input logic exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      h[i]     = '0;
      run[i]   = 0;
      m_lvl[i] = 1'b0;
    end
    m_pend = 1'b0;
    exp_a  = 1'b0;
    exp_b  = 1'b0;
  endtask

  task automatic model_edge(input logic ra, input logic rb);
    logic r [2];
    h[0] = {h[0][3:0], ra};
    h[1] = {h[1][3:0], rb};
    for (int i = 0; i < 2; i++) begin
      r[i] = 1'b0;
`ifdef BTN_COND_DEBOUNCE_EN
      // level flips once DB+1 consecutive synchronized samples disagree with it
      if (h[i][2] != m_lvl[i]) run[i]++;
      else run[i] = 0;
      if (run[i] == DB + 1) begin
        m_lvl[i] = h[i][2];
        run[i]   = 0;
        r[i]     = h[i][2];
      end
`else
      m_lvl[i] = h[i][2];
      r[i]     = h[i][3] & ~h[i][4];
`endif
    end
    exp_a  = r[0];
    exp_b  = (r[1] | m_pend) & ~r[0];
    m_pend = (r[1] | m_pend) & r[0];
  endtask

  task automatic cycle(input logic ra, input logic rb);
    bus.raw_a = ra;
    bus.raw_b = rb;
    @(posedge En);
    model_edge(ra, rb);
    edge_no++;
    @(negedge En);
    chk("a", bus.a, exp_a);
    chk("b", bus.b, exp_b);
    chk("a_lvl", bus.a_lvl, m_lvl[0]);
    chk("b_lvl", bus.b_lvl, m_lvl[1]);
    chk("a_b_excl", bus.a & bus.b, 1'b0);
    if (bus.a === 1'b1) begin
      a_cnt++;
      a_at     = edge_no;
      a_lvl_at = bus.a_lvl;
    end
    if (bus.b === 1'b1) begin
      b_cnt++;
      b_at     = edge_no;
      b_lvl_at = bus.b_lvl;
    end
    if (bus.a_lvl !== 1'b1) a_drop = 1'b1;
  endtask

  task automatic clear_stats();
    edge_no  = 0;
    a_cnt    = 0;
    b_cnt    = 0;
    a_at     = -1;
    b_at     = -1;
    a_lvl_at = 1'b0;
    b_lvl_at = 1'b0;
    a_drop   = 1'b0;
  endtask

  // Called just after a falling edge; reset falls mid-cycle and releases on the next falling edge.
  task automatic do_reset();
    #5 rst = 1'b0;
    model_reset();
    #1;
    chk("rst_a", bus.a, 1'b0);
    chk("rst_b", bus.b, 1'b0);
    chk("rst_a_lvl", bus.a_lvl, 1'b0);
    chk("rst_b_lvl", bus.b_lvl, 1'b0);
    @(negedge En);
    rst = 1'b1;
    edge_no = 0;
  endtask

  initial begin
    logic ra, rb;
    int   hold;
    rst       = 1'b0;
    bus.raw_a = 1'b0;
    bus.raw_b = 1'b0;
    model_reset();
    clear_stats();
    #5;
    chk("init_a", bus.a, 1'b0);
    chk("init_b", bus.b, 1'b0);
    chk("init_a_lvl", bus.a_lvl, 1'b0);
    chk("init_b_lvl", bus.b_lvl, 1'b0);
    @(negedge En);
    rst = 1'b1;

    // clean press on a, held 100 ns
    clear_stats();
    repeat (5) cycle(1'b1, 1'b0);
    repeat (15) cycle(1'b0, 1'b0);
    chk_int("press_a_count", a_cnt, 1);
    chk_int("press_a_edge", a_at, LAT + 1);
    chk("press_a_lvl", a_lvl_at, 1'b1);
    chk_int("press_b_count", b_cnt, 0);

    // two-cycle glitch on b
    clear_stats();
    repeat (2) cycle(1'b0, 1'b1);
    repeat (12) cycle(1'b0, 1'b0);
    chk_int("glitch_b_count", b_cnt, DEB ? 0 : 1);

    // simultaneous press on both channels
    clear_stats();
    repeat (12) cycle(1'b1, 1'b1);
    repeat (15) cycle(1'b0, 1'b0);
    chk_int("simul_a_count", a_cnt, 1);
    chk_int("simul_b_count", b_cnt, 1);
    chk_int("simul_a_edge", a_at, LAT + 1);
    chk_int("simul_b_edge", b_at, a_at + 1);

    // release bounce while a is held
    repeat (10) cycle(1'b1, 1'b0);
    clear_stats();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    repeat (10) cycle(1'b1, 1'b0);
    chk_int("bounce_a_count", a_cnt, DEB ? 0 : 2);
    chk("bounce_a_drop", a_drop, DEB ? 1'b0 : 1'b1);
    repeat (12) cycle(1'b0, 1'b0);

    // reset during a's debounce, with b held through reset release
    repeat (10) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b1, 1'b1);
    bus.raw_a = 1'b0;
    do_reset();
    clear_stats();
    repeat (15) cycle(1'b0, 1'b1);
    chk_int("stuck_b_count", b_cnt, 1);
    chk_int("stuck_b_edge", b_at, LAT + 1);
    chk("stuck_b_lvl", b_lvl_at, 1'b1);
    chk_int("midrst_a_count", a_cnt, 0);
    repeat (12) cycle(1'b0, 1'b0);

    // random activity with held levels of varying length
    hold = 0;
    ra   = 1'b0;
    rb   = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      if (hold == 0) begin
        ra   = 1'($urandom_range(0, 1));
        rb   = 1'($urandom_range(0, 1));
        hold = int'($urandom_range(1, DB + 4));
      end
      hold--;
      cycle(ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/btn_cond.md
BTN_COND -- requirements
Module: btn_cond

Interface
REQ-001 The block SHALL provide parameter `DB_CYCLES`, default 4, giving the number of consecutive stable synchronized samples required to accept a level change (legal range 1..255).
REQ-002 The block SHALL provide port `En`, input, 1 bit, system clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port `rst`, input, 1 bit, reset, asynchronous and active-low.
REQ-004 The block SHALL provide ports `raw_a` and `raw_b`, input, 1 bit each, asynchronous raw push-button levels (1 = pressed).
REQ-005 The block SHALL provide ports `a` and `b`, output, 1 bit each, single-cycle press pulses feeding the downstream `sm` block's `a` and `b` inputs.
REQ-006 The block SHALL provide ports `a_lvl` and `b_lvl`, output, 1 bit each, debounced button levels.

Function
REQ-007 Each raw input SHALL pass through a 2-flop synchronizer; its synchronized value `s_x` is valid 2 edges after the raw change is sampled.
REQ-008 Each channel SHALL run an independent 4-state FSM: LOW, RISE_CHK, HIGH, FALL_CHK.
REQ-009 LOW: `s_x=1` -> RISE_CHK, counter cleared; otherwise stay in LOW.
REQ-010 RISE_CHK: `s_x=0` -> LOW, counter cleared, no pulse; `s_x=1` increments the counter, and on reaching `DB_CYCLES` -> HIGH.
REQ-011 HIGH: `s_x=0` -> FALL_CHK, counter cleared; otherwise stay in HIGH.
REQ-012 FALL_CHK: `s_x=1` -> HIGH, counter cleared; `s_x=0` increments the counter, and on reaching `DB_CYCLES` -> LOW.
REQ-013 Counter width SHALL be `$clog2(DB_CYCLES+1)`, saturating, never wrapping.
REQ-014 `x_lvl` SHALL be 1 in HIGH and FALL_CHK and 0 in LOW and RISE_CHK, registered.
REQ-015 The RISE_CHK->HIGH transition SHALL produce exactly one `x` pulse, 1 cycle wide; release SHALL produce no pulse.
REQ-016 Latency SHALL be fixed: raw rise sampled at edge n, stable, gives `x` high during the cycle following edge n+2+`DB_CYCLES` (n+6 at default).
REQ-017 A raw glitch shorter than `DB_CYCLES` synchronized cycles SHALL produce no pulse and no `x_lvl` change.
REQ-018 Outputs `a` and `b` SHALL never be high in the same cycle.
  - If both qualify on the same edge, `a` is emitted and `b` is held in a pending flag and emitted on the next cycle.
REQ-019 If a raw input is already high when reset deasserts, it SHALL be treated as a fresh press and pulse after the REQ-016 latency.

Reset
REQ-020 `rst=0` SHALL immediately, without a clock, force:
  - synchronizer flops 0
  - both FSMs to LOW
  - counters 0
  - pending flag 0
  - `a`, `b`, `a_lvl`, `b_lvl` = 0
REQ-021 Reset asserted mid-debounce or mid-pulse SHALL abort the operation; no pulse SHALL appear after release except per REQ-019.

Configuration
REQ-022 Macro `BTN_COND_DEBOUNCE_EN` defined: the FSM and counter of REQ-008..REQ-017 SHALL be compiled in.
REQ-023 Macro `BTN_COND_DEBOUNCE_EN` undefined: FSMs and counters SHALL be compiled out, and:
  - `x_lvl` = `s_x` registered
  - `x` pulses on each 0->1 of `s_x`, high during the cycle following edge n+3
  - REQ-018 and REQ-020 still apply
  - `DB_CYCLES` is ignored

Verification
REQ-024 Reset then clean press: `rst` low 20 ns, `raw_a` 0->1 held 100 ns, clock period 20 ns -> `a` high for exactly one 20 ns cycle, 6 edges after first sampling; `a_lvl`=1; `b` stays 0.
REQ-025 Glitch: `raw_b` high for 2 cycles -> `b`=0 and `b_lvl`=0 throughout; with the macro undefined -> one `b` pulse.
REQ-026 Simultaneous: `raw_a` and `raw_b` rise on the same edge, both held -> `a` pulse at cycle k, `b` pulse at k+1, never overlapping.
REQ-027 Release bounce: after HIGH, `raw_a` toggles 1-0-1 with 1-cycle periods, then stays 1 -> `a_lvl` stays 1 and no extra `a` pulse.
REQ-028 Mid-operation reset: `rst` pulsed low during RISE_CHK of channel a, `raw_a` then held 0 -> all outputs 0 immediately and no `a` pulse afterwards.
REQ-029 Stuck-at-reset: `raw_b`=1 while `rst` deasserts -> single `b` pulse at REQ-016 latency, and `b_lvl`=1.
